sd_cmd_arbiter: RTL
===================

# sd_cmd_arbiter

Command-path sequencer and arbiter sitting between two command sources (software command register port A, data-path controller port B, e.g. auto CMD12/CMD13) and the single SD command serial host. It grants one requester at a time and runs the four-phase REQ/ACK handshake with the serial host. It follows the host's STATUS stream, captures the 40-bit response, applies a response timeout, and returns a completion record to the granted requester.

## Interface
- `TIMEOUT_CYC`, default 16'd4095: SD_CLK cycles allowed from command acceptance to final status before timeout.
- `MAX_RETRY`, default 2: CRC retries per command (used only with `SD_CMD_RETRY_EN`).
- `SD_CLK_IN` in 1: single clock, same as the serial host.
- `RST_IN` in 1: reset, synchronous, active-high.
- `A_VALID_IN` in 1: port A command request, level.
- `A_CMD_IN` in 40: port A command word (start/dir/index/argument).
- `A_SET_IN` in 16: port A setting word (host SETTING format).
- `A_ACCEPT_OUT` out 1: 1-cycle pulse when port A is granted.
- `B_VALID_IN`, `B_CMD_IN`, `B_SET_IN`, `B_ACCEPT_OUT`: same as port A, for port B.
- `DONE_OUT` out 2: 1-cycle completion pulse; bit0 is port A, bit1 is port B.
- `RSP_OUT` out 40: captured response, valid with `DONE_OUT`.
- `ERR_OUT` out 2: valid with `DONE_OUT`. 00 = ok, 01 = CRC fail, 10 = timeout.
- `HOST_CMD_OUT` out 40: to host CMD_IN.
- `HOST_SET_OUT` out 16: to host SETTING_IN.
- `HOST_REQ_OUT` out 1: to host REQ_IN.
- `HOST_ACK_IN` in 1: from host ACK_OUT.
- `HOST_REQ_IN` in 1: from host REQ_OUT (status strobe).
- `HOST_ACK_OUT` out 1: to host ACK_IN.
- `HOST_STATUS_IN` in 8: from host STATUS.
- `HOST_RSP_IN` in 40: from host CMD_OUT.
- `HOST_GO_IDLE_OUT` out 1: to host GO_IDLE, 1-cycle pulse.

## Operation
- States: IDLE, ISSUE, BUSY, CLOSE, RELEASE, TMO.
- IDLE
  - Requires `HOST_ACK_IN`=1 before granting.
  - Fixed priority: B over A.
  - On grant, latch the cmd/set into `HOST_CMD_OUT`/`HOST_SET_OUT`, record the owner, pulse the corresponding `*_ACCEPT_OUT`, clear the timeout counter, go to ISSUE.
- ISSUE
  - `HOST_REQ_OUT`=1, held until `HOST_ACK_IN`=0 (host decoder has taken the command).
  - Then drop `HOST_REQ_OUT` and go to BUSY.
- BUSY
  - When `HOST_REQ_IN`=1, sample `HOST_STATUS_IN`.
  - Intermediate codes (STATUS[3:0] = 1, 2, 3, 5): assert `HOST_ACK_OUT`=1 until `HOST_REQ_IN`=0, then deassert it.
  - Final code 6 (read done): capture `HOST_RSP_IN`, capture CRC status = STATUS[5], go to CLOSE.
  - Final code 4 (write-only done): `RSP_OUT`=0, CRC ok, go to CLOSE.
- CLOSE
  - `HOST_ACK_OUT`=1, held until `HOST_ACK_IN`=1 (host in ACK_WR/ACK_WO, then IDLE).
  - Then `HOST_ACK_OUT`=0, go to RELEASE.
- RELEASE
  - One cycle: pulse the owner's `DONE_OUT` bit.
  - `ERR_OUT`=01 only if setting bit7 (CRC check) is 1 and STATUS[5]=0; otherwise 00.
  - Return to IDLE.
- TMO
  - Entered from ISSUE, BUSY or CLOSE when the timeout counter reaches `TIMEOUT_CYC`.
  - Pulse `HOST_GO_IDLE_OUT` for 1 cycle and drop all host handshake outputs.
  - Next cycle: pulse `DONE_OUT` for the owner with `ERR_OUT`=10 and `RSP_OUT`=0, then go to IDLE.
- A new `*_VALID_IN` during a transaction is ignored until the arbiter is back in IDLE. A requester must hold valid until it sees its accept pulse.

## Timing
- Reset values: all outputs 0, `HOST_ACK_OUT`=0, `HOST_GO_IDLE_OUT`=0, state IDLE, owner A.
- Grant latency: accept pulse 1 cycle after valid is seen in IDLE; `HOST_REQ_OUT` rises in the same cycle.
- The host has 2-flop synchronisers on REQ/ACK. All handshake outputs are level-held; nothing relies on single-cycle pulses to the host.
- Timeout counter
  - 16-bit, saturating.
  - Increments every cycle in ISSUE, BUSY and CLOSE.
  - Reaching `TIMEOUT_CYC` wins over a simultaneous final status.
- Simultaneous A and B valid in IDLE: B is granted; A waits.
- `DONE_OUT` and the next accept are never in the same cycle; minimum gap is 1 cycle (IDLE).
- `RST_IN` mid-transaction: returns to IDLE with no `DONE_OUT`. `HOST_GO_IDLE_OUT` is not pulsed, because the host shares `RST_IN`.

## Configuration
- `SD_CMD_RETRY_EN` defined
  - In RELEASE, a CRC failure with retry count < `MAX_RETRY` does not pulse DONE.
  - Instead the retry count is incremented and the arbiter re-enters ISSUE with the same latched cmd/set. The timeout counter is cleared; no re-arbitration happens.
  - After `MAX_RETRY` retries the arbiter completes with `ERR_OUT`=01.
  - The retry count clears on each grant.
- `SD_CMD_RETRY_EN` undefined: a CRC failure completes immediately with `ERR_OUT`=01. No retry counter is present.

## Test plan
- Port A, cmd 40'h4C_0000_0000, set 16'h0000 (write-only) -> `HOST_REQ_OUT` held until `HOST_ACK_IN`=0. Status 2 then 4 are each acked. Response is `DONE_OUT`=01, `ERR_OUT`=00, `RSP_OUT`=0.
- Port A, set 16'h00A8 (resp 40 bits, CRC on), model returns status 6 with STATUS[5]=1 and rsp 40'h08_0000_01AA -> `RSP_OUT`=40'h08_0000_01AA, `ERR_OUT`=00.
- A and B valid in the same cycle -> `B_ACCEPT_OUT` first, `DONE_OUT`=10. `A_ACCEPT_OUT` follows ≥1 cycle after B's done, then `DONE_OUT`=01.
- Host model never returns a final status, `TIMEOUT_CYC`=16'd100 -> at count 100 a single-cycle `HOST_GO_IDLE_OUT`, then `DONE_OUT` for the owner with `ERR_OUT`=10.
- CRC-on command, model returns STATUS[5]=0 every time:
  - With `SD_CMD_RETRY_EN`: 3 ISSUE phases, then `ERR_OUT`=01.
  - Without it: 1 ISSUE phase, then `ERR_OUT`=01.
- `RST_IN` asserted during BUSY for 1 cycle -> next cycle all outputs 0, state IDLE, no `DONE_OUT`. A following port A command completes normally.

Source files
------------

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: two-port command arbiter (port B has priority over port A) in
// front of the SD command serial host. It runs the REQ/ACK handshake with the
// host, follows its STATUS stream, and captures the 40-bit response. It also
// times out stalled commands and returns a completion record to the granted
// port.
// Optional feature: define SD_CMD_RETRY_EN to re-issue CRC-failed commands up
// to MAX_RETRY times before reporting the CRC error.
module sd_cmd_arbiter #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd4095,
   parameter int          MAX_RETRY   = 2
) (
   input  logic        SD_CLK_IN,
   input  logic        RST_IN,
   input  logic        A_VALID_IN,
   input  logic [39:0] A_CMD_IN,
   input  logic [15:0] A_SET_IN,
   output logic        A_ACCEPT_OUT,
   input  logic        B_VALID_IN,
   input  logic [39:0] B_CMD_IN,
   input  logic [15:0] B_SET_IN,
   output logic        B_ACCEPT_OUT,
   output logic [1:0]  DONE_OUT,
   output logic [39:0] RSP_OUT,
   output logic [1:0]  ERR_OUT,
   output logic [39:0] HOST_CMD_OUT,
   output logic [15:0] HOST_SET_OUT,
   output logic        HOST_REQ_OUT,
   input  logic        HOST_ACK_IN,
   input  logic        HOST_REQ_IN,
   output logic        HOST_ACK_OUT,
   input  logic [7:0]  HOST_STATUS_IN,
   input  logic [39:0] HOST_RSP_IN,
   output logic        HOST_GO_IDLE_OUT
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      BUSY    = 3'd2,
      CLOSE   = 3'd3,
      RELEASE = 3'd4,
      TMO     = 3'd5
   } state_t;

   localparam logic [3:0] ST_WO_DONE = 4'd4;
   localparam logic [3:0] ST_RD_DONE = 4'd6;

   state_t      r_state, w_state;
   logic        r_owner, w_owner;        // 0 = port A, 1 = port B
   logic [39:0] r_cmd, w_cmd;
   logic [15:0] r_set, w_set;
   logic        r_a_acc, w_a_acc;
   logic        r_b_acc, w_b_acc;
   logic        r_req, w_req;
   logic        r_ack, w_ack;
   logic        r_go_idle, w_go_idle;
   logic [15:0] r_cnt, w_cnt;
   logic [39:0] r_rsp_cap, w_rsp_cap;
   logic        r_crc_ok, w_crc_ok;
   logic [1:0]  r_done, w_done;
   logic [1:0]  r_err, w_err;
   logic [39:0] r_rsp_out, w_rsp_out;

   logic        w_active;
   logic        w_tmo;
   logic        w_crc_fail;
   logic        w_retry_now;
   logic [1:0]  w_owner_done;
   logic        w_unused;

   assign w_active     = (r_state == ISSUE) || (r_state == BUSY) || (r_state == CLOSE);
   assign w_tmo        = (r_cnt >= TIMEOUT_CYC);
   // CRC failure only counts when the setting word asks for CRC checking.
   assign w_crc_fail   = r_set[7] & ~r_crc_ok;
   assign w_owner_done = r_owner ? 2'b10 : 2'b01;

`ifdef SD_CMD_RETRY_EN
   logic [7:0]  r_retry, w_retry;
   assign w_retry_now = w_crc_fail && (r_retry < 8'(MAX_RETRY));
   assign w_unused    = ^{HOST_STATUS_IN[7:6], HOST_STATUS_IN[4]};
`else
   assign w_retry_now = 1'b0;
   assign w_unused    = ^{HOST_STATUS_IN[7:6], HOST_STATUS_IN[4], MAX_RETRY};
`endif

   // Next-state and next register values; pulses default low, the rest hold.
   always_comb begin
      w_state   = r_state;
      w_owner   = r_owner;
      w_cmd     = r_cmd;
      w_set     = r_set;
      w_a_acc   = 1'b0;
      w_b_acc   = 1'b0;
      w_req     = r_req;
      w_ack     = r_ack;
      w_go_idle = 1'b0;
      w_cnt     = r_cnt;
      w_rsp_cap = r_rsp_cap;
      w_crc_ok  = r_crc_ok;
      w_done    = 2'b00;
      w_err     = r_err;
      w_rsp_out = r_rsp_out;
`ifdef SD_CMD_RETRY_EN
      w_retry   = r_retry;
`endif

      // Saturating timeout counter, running while a command is outstanding.
      if (w_active && (r_cnt != 16'hFFFF))
         w_cnt = r_cnt + 16'd1;

      // Timeout takes precedence over anything the host reports this cycle.
      if (w_active && w_tmo) begin
         w_state   = TMO;
         w_req     = 1'b0;
         w_ack     = 1'b0;
         w_go_idle = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               // Hold off one cycle after a completion so DONE and accept never coincide.
               if (HOST_ACK_IN && (r_done == 2'b00) && (A_VALID_IN || B_VALID_IN)) begin
                  w_owner = B_VALID_IN;
                  w_cmd   = B_VALID_IN ? B_CMD_IN : A_CMD_IN;
                  w_set   = B_VALID_IN ? B_SET_IN : A_SET_IN;
                  w_a_acc = ~B_VALID_IN;
                  w_b_acc = B_VALID_IN;
                  w_req   = 1'b1;
                  w_cnt   = 16'd0;
`ifdef SD_CMD_RETRY_EN
                  w_retry = 8'd0;
`endif
                  w_state = ISSUE;
               end
            end
            ISSUE: begin
               // Host drops its ACK once its decoder has taken the command.
               if (!HOST_ACK_IN) begin
                  w_req   = 1'b0;
                  w_state = BUSY;
               end
            end
            BUSY: begin
               if (r_ack) begin
                  if (!HOST_REQ_IN)
                     w_ack = 1'b0;
               end else if (HOST_REQ_IN) begin
                  w_ack = 1'b1;
                  if (HOST_STATUS_IN[3:0] == ST_RD_DONE) begin
                     w_rsp_cap = HOST_RSP_IN;
                     w_crc_ok  = HOST_STATUS_IN[5];
                     w_state   = CLOSE;
                  end else if (HOST_STATUS_IN[3:0] == ST_WO_DONE) begin
                     w_rsp_cap = 40'd0;
                     w_crc_ok  = 1'b1;
                     w_state   = CLOSE;
                  end
               end
            end
            CLOSE: begin
               // Host back in IDLE (ACK high) closes the final handshake.
               if (HOST_ACK_IN) begin
                  w_ack   = 1'b0;
                  w_state = RELEASE;
                  if (!w_retry_now) begin
                     w_done    = w_owner_done;
                     w_err     = w_crc_fail ? 2'b01 : 2'b00;
                     w_rsp_out = r_rsp_cap;
                  end
               end
            end
            RELEASE: begin
               w_state = IDLE;
`ifdef SD_CMD_RETRY_EN
               if (w_retry_now) begin
                  w_retry = r_retry + 8'd1;
                  w_cnt   = 16'd0;
                  w_req   = 1'b1;
                  w_state = ISSUE;
               end
`endif
            end
            TMO: begin
               w_done    = w_owner_done;
               w_err     = 2'b10;
               w_rsp_out = 40'd0;
               w_state   = IDLE;
            end
            default: w_state = IDLE;
         endcase
      end
   end

   // State and output registers; reset clears every output and returns to IDLE.
   always_ff @(posedge SD_CLK_IN) begin
      if (RST_IN) begin
         r_state   <= IDLE;
         r_owner   <= 1'b0;
         r_cmd     <= 40'd0;
         r_set     <= 16'd0;
         r_a_acc   <= 1'b0;
         r_b_acc   <= 1'b0;
         r_req     <= 1'b0;
         r_ack     <= 1'b0;
         r_go_idle <= 1'b0;
         r_cnt     <= 16'd0;
         r_rsp_cap <= 40'd0;
         r_crc_ok  <= 1'b0;
         r_done    <= 2'b00;
         r_err     <= 2'b00;
         r_rsp_out <= 40'd0;
`ifdef SD_CMD_RETRY_EN
         r_retry   <= 8'd0;
`endif
      end else begin
         r_state   <= w_state;
         r_owner   <= w_owner;
         r_cmd     <= w_cmd;
         r_set     <= w_set;
         r_a_acc   <= w_a_acc;
         r_b_acc   <= w_b_acc;
         r_req     <= w_req;
         r_ack     <= w_ack;
         r_go_idle <= w_go_idle;
         r_cnt     <= w_cnt;
         r_rsp_cap <= w_rsp_cap;
         r_crc_ok  <= w_crc_ok;
         r_done    <= w_done;
         r_err     <= w_err;
         r_rsp_out <= w_rsp_out;
`ifdef SD_CMD_RETRY_EN
         r_retry   <= w_retry;
`endif
      end
   end

   assign A_ACCEPT_OUT     = r_a_acc;
   assign B_ACCEPT_OUT     = r_b_acc;
   assign DONE_OUT         = r_done;
   assign RSP_OUT          = r_rsp_out;
   assign ERR_OUT          = r_err;
   assign HOST_CMD_OUT     = r_cmd;
   assign HOST_SET_OUT     = r_set;
   assign HOST_REQ_OUT     = r_req;
   assign HOST_ACK_OUT     = r_ack;
   assign HOST_GO_IDLE_OUT = r_go_idle;

endmodule
